// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-command type used by the
// writeback arbiter and anything else that talks to the 32x32 register file.
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int ZERO_REG   = 0;

  // One register-file write command: enable, destination, data.
  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } rf_wr_cmd_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter. Searches the request vector starting
// at rr_ptr and wrapping modulo NUM_REQ; the first set bit wins. The pointer
// register itself lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // One extra bit so rr_ptr + offset never overflows before the wrap.
  logic [IDX_W:0] pos;

  // Scan from the farthest offset back to rr_ptr so the nearest request wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    pos         = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
        pos = pos - (IDX_W + 1)'(NUM_REQ);
      end
      if (req[pos[IDX_W-1:0]]) begin
        grant                 = '0;
        grant[pos[IDX_W-1:0]] = 1'b1;
        grant_idx             = pos[IDX_W-1:0];
        grant_valid           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: shares the single write port among
// NUM_REQ writeback sources with a valid/ready handshake and a registered
// write command one cycle after acceptance. Writes to x0 are accepted but
// never enabled toward the register file.
// Build option: define REGARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer); default is round-robin.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      arb_enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_regwrite,
  output logic [ADDR_W-1:0]         rf_write_reg,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      rf_write_fire
);

  logic [NUM_REQ-1:0] req_eligible;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic [ADDR_W-1:0]  req_reg_arr  [NUM_REQ];
  logic [DATA_W-1:0]  req_data_arr [NUM_REQ];
  logic [ADDR_W-1:0]  sel_reg;
  logic [DATA_W-1:0]  sel_data;

  // Nothing is granted while disabled or while reset is held, so no source
  // sees ready during reset.
  assign req_eligible = (arb_enable && !reset) ? req_valid : '0;

  // Unpack the flat per-source buses.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_reg_arr[gi]  = req_reg[gi*ADDR_W +: ADDR_W];
    assign req_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

`ifdef REGARB_FIXED_PRIO_EN
  // Fixed priority: lowest eligible index wins, independent of history.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_eligible[i]) begin
        grant_onehot    = '0;
        grant_onehot[i] = 1'b1;
        grant_idx       = IDX_W'(i);
        grant_valid     = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_reg;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req         (req_eligible),
    .rr_ptr      (rr_ptr_reg),
    .grant       (grant_onehot),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Advance the pointer past the winner on each transfer; hold otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= '0;
    end else if (grant_valid) begin
      if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
        rr_ptr_reg <= '0;
      end else begin
        rr_ptr_reg <= grant_idx + 1'b1;
      end
    end
  end
`endif

  // Ready goes only to the granted source; a grant implies a transfer.
  assign req_ready = grant_onehot;
  assign sel_reg   = req_reg_arr[grant_idx];
  assign sel_data  = req_data_arr[grant_idx];

  // Register the accepted command; idle cycles drop the strobes and hold
  // the address/data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_regwrite   <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      grant_id      <= '0;
      rf_write_fire <= 1'b0;
    end else if (grant_valid) begin
      rf_regwrite   <= (sel_reg != ADDR_W'(ZERO_REG));
      rf_write_reg  <= sel_reg;
      rf_write_data <= sel_data;
      grant_id      <= grant_idx;
      rf_write_fire <= 1'b1;
    end else begin
      rf_regwrite   <= 1'b0;
      rf_write_fire <= 1'b0;
    end
  end

endmodule
